// File: rtl/id_stage_pkg.sv
// id_stage_pkg: ALU op codes, RV64I opcode/funct constants and decode output record shared with the ALU.
package id_stage_pkg;
  localparam int ALUOP_WIDTH = 5;
  typedef logic [ALUOP_WIDTH-1:0] aluop_t;
  localparam aluop_t ALU_ADD    = 5'd0;
  localparam aluop_t ALU_SUB    = 5'd1;
  localparam aluop_t ALU_AND    = 5'd2;
  localparam aluop_t ALU_OR     = 5'd3;
  localparam aluop_t ALU_XOR    = 5'd4;
  localparam aluop_t ALU_SLT    = 5'd5;
  localparam aluop_t ALU_SLTU   = 5'd6;
  localparam aluop_t ALU_SLL    = 5'd7;
  localparam aluop_t ALU_SRL    = 5'd8;
  localparam aluop_t ALU_SRA    = 5'd9;
  localparam aluop_t ALU_ADDW   = 5'd10;
  localparam aluop_t ALU_SUBW   = 5'd11;
  localparam aluop_t ALU_SLLW   = 5'd12;
  localparam aluop_t ALU_SRLW   = 5'd13;
  localparam aluop_t ALU_SRAW   = 5'd14;
  localparam aluop_t ALU_PASS_B = 5'd20;
  localparam aluop_t ALU_LINK   = 5'd21;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] F7_BASE      = 7'h00;
  localparam logic [6:0] F7_ALT       = 7'h20;
  typedef struct packed {
    aluop_t      aluop;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
  } id_out_t;
  function automatic aluop_t alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return alt ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic aluop_t alu_w(input logic [2:0] f3, input logic alt);
    return f3 == 3'd1 ? ALU_SLLW : f3 == 3'd5 ? (alt ? ALU_SRAW : ALU_SRLW) : (alt ? ALU_SUBW : ALU_ADDW);
  endfunction
endpackage

// File: rtl/id_decode.sv
// id_decode: combinational RV64I decode of one instruction into ALU op, operands, rd and write enable.
module id_decode
  import id_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [63:0] pc,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  output aluop_t      aluop,
  output logic [63:0] a,
  output logic [63:0] b,
  output logic [4:0]  rd,
  output logic        wen,
  output logic        illegal
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [63:0] imm_i, imm_u, sa, sb;
  aluop_t sel;
  logic ok;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'd0};
  always_comb begin
    ok = 1'b1;
    sel = ALU_ADD;
    sa = rs1;
    sb = rs2;
    case (op)
      OPC_OP: begin
        ok = f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5));
        sel = alu_f3(f3, instr[30]);
      end
      OPC_OP_IMM: begin
        ok = f3 == 3'd1 ? instr[31:26] == 6'd0 : f3 != 3'd5 || instr[31:26] == 6'd0 || instr[31:26] == 6'b010000;
        sel = alu_f3(f3, f3 == 3'd5 && instr[30]);
        sb = f3 == 3'd1 || f3 == 3'd5 ? {58'd0, instr[25:20]} : imm_i;
      end
      OPC_OP_IMM32: begin
        // W shifts only have a 5-bit shamt, so instr[25] set is reserved
        ok = f3 == 3'd0 || (f3 == 3'd1 && f7 == F7_BASE) || (f3 == 3'd5 && (f7 == F7_BASE || f7 == F7_ALT));
        sel = alu_w(f3, f3 == 3'd5 && instr[30]);
        sb = f3 == 3'd0 ? imm_i : {59'd0, instr[24:20]};
      end
      OPC_OP32: begin
        ok = (f7 == F7_BASE && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5));
        sel = alu_w(f3, instr[30]);
      end
      OPC_LUI: begin
        sel = ALU_PASS_B;
        sa = '0;
        sb = imm_u;
      end
      OPC_AUIPC: begin
        sa = pc;
        sb = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        ok = op == OPC_JAL || f3 == 3'd0;
        sel = ALU_LINK;
        sa = '0;
        sb = pc;
      end
      default: ok = 1'b0;
    endcase
  end
  assign illegal = ~ok;
  assign aluop = ok ? sel : ALU_ADD;
  assign a = ok ? sa : '0;
  assign b = ok ? sb : '0;
  assign rd = instr[11:7];
  assign wen = ok && rd != 5'd0;
endmodule

// File: rtl/id_stage.sv
// id_stage: RV64I decode stage with valid/ready handshake and output register; ID_SKID_EN adds a one-entry skid buffer.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_pc,
  input  logic [31:0]            in_instr,
  input  logic [63:0]            rs1_data,
  input  logic [63:0]            rs2_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_a,
  output logic [63:0]            out_b,
  output logic [ALUOP_WIDTH-1:0] out_aluop,
  output logic [63:0]            out_pc,
  output logic [4:0]             out_rd,
  output logic                   out_wen,
  output logic                   out_illegal
);
  id_out_t dec, out_q;
  aluop_t d_op;
  logic [63:0] d_a, d_b;
  logic [4:0] d_rd;
  logic d_wen, d_ill, acc, load;
  id_decode u_dec (
    .instr(in_instr), .pc(in_pc), .rs1(rs1_data), .rs2(rs2_data),
    .aluop(d_op), .a(d_a), .b(d_b), .rd(d_rd), .wen(d_wen), .illegal(d_ill)
  );
  assign dec = '{aluop: d_op, a: d_a, b: d_b, pc: in_pc, rd: d_rd, wen: d_wen, illegal: d_ill};
  assign acc = in_valid & in_ready;
  assign load = ~out_valid | out_ready;
`ifdef ID_SKID_EN
  id_out_t skid_q;
  logic skid_full;
  // in_ready depends only on state (and reset), never on out_ready
  assign in_ready = rst_n & ~skid_full;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
      out_q <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (load) begin
      out_valid <= skid_full | acc;
      skid_full <= 1'b0;
      if (skid_full) out_q <= skid_q;
      else if (acc) out_q <= dec;
    end else if (acc) begin
      skid_full <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (acc && !load) skid_q <= dec;
`else
  assign in_ready = rst_n & load;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) out_q <= dec;
    end
  end
`endif
  assign out_aluop = out_q.aluop;
  assign out_a = out_q.a;
  assign out_b = out_q.b;
  assign out_pc = out_q.pc;
  assign out_rd = out_q.rd;
  assign out_wen = out_q.wen;
  assign out_illegal = out_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage, valid with or without ID_SKID_EN.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b1;
  logic [63:0] in_pc = '0, rs1_data = '0, rs2_data = '0;
  logic [31:0] in_instr = '0;
  logic [63:0] out_a, out_b, out_pc;
  logic [4:0] out_aluop, out_rd;
  logic out_wen, out_illegal;
  int total = 0, bad = 0;
  id_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_aluop(out_aluop), .out_pc(out_pc), .out_rd(out_rd), .out_wen(out_wen),
    .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", t, obs, exp);
    end
  endtask
  task automatic chk_out(input string t, input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic wen, input logic ill);
    chk({t, ".valid"}, out_valid, 1);
    chk({t, ".aluop"}, out_aluop, op);
    chk({t, ".a"}, out_a, a);
    chk({t, ".b"}, out_b, b);
    chk({t, ".rd"}, out_rd, rd);
    chk({t, ".wen"}, out_wen, wen);
    chk({t, ".ill"}, out_illegal, ill);
  endtask
  task automatic issue(input logic [31:0] i, input logic [63:0] pc, input logic [63:0] r1, input logic [63:0] r2);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = i;
    in_pc = pc;
    rs1_data = r1;
    rs2_data = r2;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic chk_zero(input string t);
    chk({t, ".valid"}, out_valid, 0);
    chk({t, ".a"}, out_a, 0);
    chk({t, ".b"}, out_b, 0);
    chk({t, ".pc"}, out_pc, 0);
    chk({t, ".aluop"}, out_aluop, 0);
    chk({t, ".rd"}, out_rd, 0);
    chk({t, ".wen"}, out_wen, 0);
    chk({t, ".ill"}, out_illegal, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] seq_instr [3];
    logic [63:0] ha;
    logic [4:0] hr;
    logic held;
    int sent, got;
    seq_instr = '{32'h00008593, 32'h00008613, 32'h00008693};
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk_zero("rst");
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    issue(32'hFFF08293, 64'h1000, 64'd10, 64'd0);
    chk_out("addi", 5'd0, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 1'b1, 1'b0);
    chk("addi.pc", out_pc, 64'h1000);
    issue(32'h41F2519B, 64'h1004, 64'h77, 64'd0);
    chk_out("sraiw", 5'd14, 64'h77, 64'd31, 5'd3, 1'b1, 1'b0);
    issue(32'h43F2519B, 64'h1008, 64'h77, 64'd0);
    chk_out("sraiw_bad", 5'd0, 64'd0, 64'd0, 5'd3, 1'b0, 1'b1);
    issue(32'h000000EF, 64'h8000_0000, 64'h5, 64'h6);
    chk_out("jal", 5'd21, 64'd0, 64'h8000_0000, 5'd1, 1'b1, 1'b0);
    issue(32'h12345037, 64'h100c, 64'h5, 64'h6);
    chk_out("lui_x0", 5'd20, 64'd0, 64'h1234_5000, 5'd0, 1'b0, 1'b0);
    issue(32'h80000137, 64'h1010, 64'h5, 64'h6);
    chk_out("lui_neg", 5'd20, 64'd0, 64'hFFFF_FFFF_8000_0000, 5'd2, 1'b1, 1'b0);
    issue(32'h40208333, 64'h1014, 64'h123, 64'h456);
    chk_out("sub", 5'd1, 64'h123, 64'h456, 5'd6, 1'b1, 1'b0);
    issue(32'h00001397, 64'h2000, 64'h5, 64'h6);
    chk_out("auipc", 5'd0, 64'h2000, 64'h1000, 5'd7, 1'b1, 1'b0);
    issue(32'h03F09093, 64'h2004, 64'h9, 64'h6);
    chk_out("slli63", 5'd7, 64'h9, 64'd63, 5'd1, 1'b1, 1'b0);
    issue(32'h0F00F493, 64'h2008, 64'hAB, 64'h6);
    chk_out("andi", 5'd2, 64'hAB, 64'hF0, 5'd9, 1'b1, 1'b0);
    issue(32'h4020D533, 64'h200c, 64'h11, 64'h22);
    chk_out("sra", 5'd9, 64'h11, 64'h22, 5'd10, 1'b1, 1'b0);
    issue(32'h40209533, 64'h2010, 64'h11, 64'h22);
    chk_out("r_bad_f7", 5'd0, 64'd0, 64'd0, 5'd10, 1'b0, 1'b1);
    issue(32'h00000000, 64'h2014, 64'h11, 64'h22);
    chk_out("bad_opc", 5'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1);
    tick();
    chk("idle_valid", out_valid, 0);
    sent = 0;
    got = 0;
    held = 1'b0;
    ha = '0;
    hr = '0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      out_ready = !(c == 1 || c == 2);
      in_valid = sent < 3;
      in_instr = seq_instr[sent < 3 ? sent : 2];
      rs1_data = 64'(11 + sent);
      #1;
      if (held) begin
        chk("stall_hold_a", out_a, ha);
        chk("stall_hold_rd", out_rd, hr);
        chk("stall_hold_valid", out_valid, 1);
      end
      if (c == 2) chk("stall_in_ready", in_ready, 0);
      held = out_valid & ~out_ready;
      ha = out_a;
      hr = out_rd;
      if (out_valid && out_ready) begin
        chk("seq_rd", out_rd, 5'(11 + got));
        chk("seq_a", out_a, 64'(11 + got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    chk("seq_count", got, 3);
    chk("seq_drained", out_valid, 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = seq_instr[0];
    rs1_data = 64'h55;
    tick();
    in_instr = seq_instr[1];
    tick();
    in_instr = seq_instr[2];
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("flush_quiet", out_valid, 0);
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'hFFF08293;
    rs1_data = 64'd10;
    in_pc = 64'h3000;
    tick();
    in_valid = 1'b0;
    chk("rst_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    tick();
    chk_zero("mid_rst");
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    issue(32'h00008613, 64'h3004, 64'd12, 64'd0);
    chk_out("after_rst", 5'd0, 64'd12, 64'd0, 5'd12, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 in_valid  in  1  fetch slot carries an instruction.
REQ-004 in_ready  out  1  stage accepts in this cycle; transfer = in_valid & in_ready at clk edge.
REQ-005 in_pc  in  64  instruction address; in_instr  in  32  RV64I instruction word.
REQ-006 rs1_data, rs2_data  in  64 each  register-file read data for in_instr, valid with in_valid.
REQ-007 flush  in  1  discard all held and incoming instructions.
REQ-008 out_valid  out  1; out_ready  in  1  execute handshake; transfer = out_valid & out_ready.
REQ-009 out_a, out_b  out  64 each  ALU operands A, B.
REQ-010 out_aluop  out  ALUOP_WIDTH  ALU operation code.
REQ-011 out_pc  out  64; out_rd  out  5; out_wen  out  1; out_illegal  out  1.

Function
REQ-012 Latency one cycle: instruction accepted at edge N appears on outputs after edge N, out_valid=1.
REQ-013 While out_valid & !out_ready, all out_* SHALL hold stable.
REQ-014 Without skid: in_ready = !out_valid | out_ready (combinational).
REQ-015 aluop map: ADD/ADDI 0, SUB 1, AND/ANDI 2, OR/ORI 3, XOR/XORI 4, SLT/SLTI 5, SLTU/SLTIU 6, SLL/SLLI 7, SRL/SRLI 8, SRA/SRAI 9, ADDW/ADDIW 10, SUBW 11, SLLW/SLLIW 12, SRLW/SRLIW 13, SRAW/SRAIW 14.
REQ-016 R-type: A=rs1_data, B=rs2_data. I-type arithmetic: A=rs1_data, B=12-bit imm sign-extended to 64.
REQ-017 Shift-immediates: B={58'b0,instr[25:20]} (64-bit) or {59'b0,instr[24:20]} (W forms); instr[30] selects SRA/SRL.
REQ-018 LUI: aluop 20, A=0, B=sign-extended {instr[31:12],12'b0}.
REQ-019 AUIPC: aluop 0, A=in_pc, B=sign-extended {instr[31:12],12'b0}.
REQ-020 JAL/JALR: aluop 21, A=0, B=in_pc (link value pc+4); target computation out of scope.
REQ-021 Any other opcode, reserved funct3/funct7, or W-shift with instr[25]=1: out_illegal=1, aluop 0, A=B=0, out_wen=0; still passes through handshake.
REQ-022 out_wen=1 for every legal instruction with rd!=0; rd=0 forces out_wen=0; out_rd=instr[11:7].
REQ-023 flush=1 at an edge: out_valid=0 and skid entry emptied after that edge; simultaneous accept is dropped; flush dominates out_ready and in_valid.
REQ-024 out_ready with out_valid=0 is ignored; in_instr ignored when in_valid=0.

Reset
REQ-025 rst_n=0 at an edge: out_valid=0, out_a=out_b=out_pc=0, out_aluop=0, out_rd=0, out_wen=0, out_illegal=0, skid empty.
REQ-026 in_ready=0 while rst_n=0; first possible accept at first edge with rst_n=1.
REQ-027 Reset mid-stall discards held instruction; no output transfer completes on the reset edge.

Configuration
REQ-028 Macro ID_SKID_EN defined: one-entry skid buffer; in_ready is a register output (=skid empty), no combinational path out_ready->in_ready; an instruction arriving while output stalls goes into skid, drains to output on next out transfer; throughput one per cycle.
REQ-029 ID_SKID_EN undefined: no skid storage; in_ready per REQ-014; all other behaviour identical.

Structure
REQ-030 ALUOP_WIDTH (5) and named aluop constants (ADD..SRAW, PASS_B=20, LINK=21) SHALL live in the shared param package also used by the ALU; opcode/funct constants likewise.
REQ-031 One sub-module, id_decode: purely combinational instr/pc/rs data -> aluop, A, B, rd, wen, illegal; id_stage holds handshake, output register, skid.

Verification
REQ-032 ADDI x5,x1,-1 (0xFFF08293), rs1_data=10, out_ready=1 -> next cycle out_aluop=0, out_a=10, out_b=0xFFFF_FFFF_FFFF_FFFF, out_rd=5, out_wen=1.
REQ-033 SRAIW x3,x4,31 (0x41F2519B) -> aluop 14, out_b=31; same with instr[25]=1 (0x43F2519B) -> out_illegal=1, out_wen=0.
REQ-034 JAL x1 at in_pc=0x8000_0000 -> aluop 21, out_a=0, out_b=0x8000_0000, out_wen=1; LUI x0 -> aluop 20, out_wen=0.
REQ-035 Three back-to-back instructions, out_ready low 2 cycles after first -> outputs stable while stalled, all three delivered in order, none lost/duplicated (both macro settings).
REQ-036 flush asserted same edge as accept with skid full and output stalled -> out_valid=0 next cycle, in_ready=1, neither held nor incoming instruction ever appears.
REQ-037 rst_n low for one edge during stall -> all outputs zero, in_ready=0 during reset, normal accept on next edge.
